// File: rtl/mult_div_unit_pkg.sv
// Shared types for the EXE-stage multiply/divide unit.
// Op encodings, FSM states and default divide length.
package CPU_Defines;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } multdiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } multdiv_state_t;

  localparam int DIV_CYCLES_DEFAULT = 32;

  function automatic logic op_is_div(
    input multdiv_op_t op
  );
    return (op == OP_DIV) ||
           (op == OP_DIVU);
  endfunction

  function automatic logic op_is_smul(
    input multdiv_op_t op
  );
    return (op == OP_MULT) ||
           (op == OP_MADD) ||
           (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 divider, one quotient bit per cycle.
// Works on magnitudes and applies the sign fix on the final bit.
module div_radix2
  import CPU_Defines::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  input  logic        abort,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          active;
  logic [31:0]   rem_q;
  logic [31:0]   quo_q;
  logic [31:0]   dsr_q;
  logic          neg_q;
  logic          neg_r;

  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_abs;
  logic [31:0]   b_abs;
  logic [32:0]   shifted;
  logic [32:0]   trial;
  logic          fits;
  logic [31:0]   rem_n;
  logic [31:0]   quo_n;

  // Operand magnitudes for signed division.
  always_comb begin
    a_neg = is_signed & dividend[31];
    b_neg = is_signed & divisor[31];
    a_abs = a_neg ? -dividend : dividend;
    b_abs = b_neg ? -divisor : divisor;
  end

  // One restoring step plus the sign-fixed view of its result.
  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    trial     = shifted - {1'b0, dsr_q};
    fits      = ~trial[32];
    rem_n     = fits ? trial[31:0]
                     : shifted[31:0];
    quo_n     = {quo_q[30:0], fits};
    quotient  = neg_q ? -quo_n : quo_n;
    remainder = neg_r ? -rem_n : rem_n;
    done      = active &&
                (cnt == CW'(DIV_CYCLES - 1));
  end

  // Counter and partial-remainder state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (abort) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      rem_q  <= '0;
      quo_q  <= a_abs;
      dsr_q  <= b_abs;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (done) begin
        cnt    <= '0;
        active <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EXE-stage iterative multiply/divide with HILO write-back.
// Define HILO_ACC_EN to enable MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
  import CPU_Defines::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  EXE_MultDivOp,
  input  logic [31:0] EXE_rs_value,
  input  logic [31:0] EXE_rt_value,
  input  logic [31:0] EXE_HI,
  input  logic [31:0] EXE_LO,
  input  logic        EXE_DisWr,
  input  logic        EXE_Wr,
  output logic        DIVMULTBusy,
  output logic [31:0] MULTDIV_HI,
  output logic [31:0] MULTDIV_LO,
  output logic        MULTDIV_Valid
);

  multdiv_state_t state;
  multdiv_state_t state_n;
  multdiv_op_t    op_in;
  multdiv_op_t    op_q;

  logic        op_ok;
  logic        start;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [63:0] mul_res;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_done;

  assign op_in = multdiv_op_t'(EXE_MultDivOp);

  // Which encodings this build accepts.
  always_comb begin
    op_ok = 1'b0;
    case (op_in)
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU:  op_ok = 1'b1;
`ifdef HILO_ACC_EN
      OP_MADD,
      OP_MADDU,
      OP_MSUB,
      OP_MSUBU: op_ok = 1'b1;
`endif
      default:  op_ok = 1'b0;
    endcase
  end

  assign start = (state == S_IDLE) &&
                 op_ok && EXE_DisWr;

  // Capture operands at issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_NONE;
    end else if (start) begin
      a_q  <= EXE_rs_value;
      b_q  <= EXE_rt_value;
      op_q <= op_in;
    end
  end

`ifdef HILO_ACC_EN
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Capture the accumulator at issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (start) begin
      hi_q <= EXE_HI;
      lo_q <= EXE_LO;
    end
  end
`else
  logic unused_hilo;
  assign unused_hilo = ^{EXE_HI, EXE_LO};
`endif

  // 64-bit product and optional accumulate.
  always_comb begin
    a_ext = op_is_smul(op_q)
          ? {{32{a_q[31]}}, a_q}
          : {32'b0, a_q};
    b_ext = op_is_smul(op_q)
          ? {{32{b_q[31]}}, b_q}
          : {32'b0, b_q};
    prod    = a_ext * b_ext;
    mul_res = prod;
`ifdef HILO_ACC_EN
    if (op_q == OP_MADD ||
        op_q == OP_MADDU)
      mul_res = {hi_q, lo_q} + prod;
    else if (op_q == OP_MSUB ||
             op_q == OP_MSUBU)
      mul_res = {hi_q, lo_q} - prod;
`endif
  end

  div_radix2 #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (start && op_is_div(op_in)),
    .dividend  (EXE_rs_value),
    .divisor   (EXE_rt_value),
    .is_signed (op_in == OP_DIV),
    .abort     (~EXE_DisWr),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Next state, stall request and write enable.
  always_comb begin
    state_n       = state;
    DIVMULTBusy   = 1'b0;
    MULTDIV_Valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        DIVMULTBusy = start;
        if (start)
          state_n = op_is_div(op_in)
                  ? S_DIV : S_MUL;
      end
      S_MUL: begin
        DIVMULTBusy = 1'b1;
        state_n     = S_DONE;
      end
      S_DIV: begin
        DIVMULTBusy = 1'b1;
        if (div_done)
          state_n = S_DONE;
      end
      S_DONE: begin
        MULTDIV_Valid = 1'b1;
        if (EXE_Wr)
          state_n = S_IDLE;
      end
    endcase
    if (!EXE_DisWr) begin
      state_n       = S_IDLE;
      DIVMULTBusy   = 1'b0;
      MULTDIV_Valid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Result registers, loaded on the last compute cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MULTDIV_HI <= '0;
      MULTDIV_LO <= '0;
    end else if (EXE_DisWr) begin
      if (state == S_MUL) begin
        MULTDIV_HI <= mul_res[63:32];
        MULTDIV_LO <= mul_res[31:0];
      end else if (state == S_DIV &&
                   div_done) begin
        MULTDIV_HI <= div_rem;
        MULTDIV_LO <= div_quo;
      end
    end
  end

endmodule
